pattern_word_gen: RTL
=====================

// Module: pattern_word_gen
// PURPOSE
//  Transmit-side counterpart of detect_pattern. Given a requested occurrence count N, it builds
//  a WIDTH-bit word containing exactly N occurrences of 3'b010, overlaps counted. detect_pattern
//  reports that same N for the word.
//  The word is emitted serially, LSB first, over a valid/ready stream, and is also presented in
//  parallel when complete. It is the stimulus and loopback source for the detector datapath.
// PARAMETERS
//  WIDTH  32  word length in bits; must satisfy WIDTH >= 2*(2**CNT_W-1)+2
//  CNT_W  4   width of the requested count; maximum N = 2**CNT_W-1 (15)
// PORTS
//  clk          in   1       single clock, rising edge
//  rst          in   1       asynchronous, active-high reset
//  start        in   1       request pulse; sampled only in IDLE
//  req_count    in   CNT_W   occurrence count N; latched when start is accepted
//  busy         out  1       high from the cycle after start is accepted until word_valid
//  dout         out  1       serial bit, LSB first
//  dout_valid   out  1       dout is valid
//  dout_ready   in   1       sink accepts dout on this edge when dout_valid is also high
//  word_out     out  WIDTH   assembled word; holds its value until the next accepted start
//  word_valid   out  1       one-cycle pulse when word_out is complete
// BEHAVIOUR
//  - Reset (async assert, registered deassert): FSM=IDLE, bit index=0, count register=0, busy=0,
//    dout=0, dout_valid=0, word_valid=0, word_out=0.
//  - Bit rule for index i in 0..WIDTH-1: bit = (i > 2N) ? 1'b1 : i[0].
//    Bits 0..2N alternate 0,1,0,... and the remaining upper bits are filled with 1s.
//    This yields exactly N windows equal to 010. The 0->1->1 tail cannot create an extra match.
//  - FSM IDLE -> SHIFT -> DONE -> IDLE.
//  - IDLE: when start=1, latch N, clear the index, set busy and clear word_out. The next state is
//    SHIFT. dout_valid goes high on the following cycle, presenting bit 0.
//  - SHIFT: dout_valid=1 and dout=bit(index).
//    A transfer happens when dout_valid && dout_ready: shift the bit into word_out[index] and
//    increment the index.
//    While dout_ready=0, dout, index and word_out hold; the bit is never dropped or duplicated.
//    A transfer at index WIDTH-1 moves the FSM to DONE and drops dout_valid in that same cycle.
//  - DONE (one cycle): word_valid=1 and busy=0 on the next edge; the FSM returns to IDLE.
//  - Latency with dout_ready held high: start edge -> word_valid = WIDTH+1 cycles (33 at default).
//  - A start while busy (SHIFT or DONE) is ignored. req_count changes after acceptance have
//    no effect.
//  - A start in the same cycle as word_valid is ignored. The earliest new start is the cycle
//    after word_valid.
//  - The index is CLOG2(WIDTH) bits wide and never wraps: it saturates into the DONE transition.
//  - Reset mid-SHIFT aborts the word immediately and returns all outputs to their reset values.
//    No word_valid is produced.
//  - Comparison i > 2N uses an index-width compare after zero-extending 2N; no overflow at N=15.
// STRUCTURE
//  - pattern_pkg: PATTERN = 3'b010, the typedef enum logic [1:0] {IDLE, SHIFT, DONE} gen_state_t,
//    and the function pattern_bit(idx, n) implementing the bit rule.
//    detect_pattern and this block share this package.
//  - No sub-module: the FSM, index counter and word shift register live in one module.
// TESTING (check word_out against the detect_pattern count in loopback)
//  - N=0, dout_ready=1 -> word_out=32'hFFFFFFFE, word_valid 33 cycles after start, count=0.
//  - N=1 -> word_out=32'hFFFFFFFA, count=1. N=2 -> word_out=32'hFFFFFFEA, count=2.
//  - N=15 -> word_out=32'hAAAAAAAA, count=15. Serial bits 0..31 observed as 0,1,0,1,...,1.
//  - N=5, dout_ready low for 3 cycles at index 4 and 2 cycles at index 20 -> dout stable while
//    stalled; word_out=32'hFFFFF800|32'h2AA; word_valid at 38 cycles.
//  - Second start (N=7) at index 10 of an N=3 word -> ignored; word_out=32'hFFFFFF2A|32'h80=
//    32'hFFFFFFAA.
//  - rst pulse at index 12 -> outputs cleared at once, no word_valid; next start N=4 ->
//    word_out=32'hFFFFFEAA.

Source files
------------

// File: rtl/pattern_pkg.sv
// pattern_pkg: shared match pattern, generator FSM states and the generator bit rule
package pattern_pkg;

    localparam logic [2:0] PATTERN = 3'b010;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} gen_state_t;

    // Alternating 0,1,0,... up to index 2n, then all ones: exactly n overlapping PATTERN windows.
    function automatic logic pattern_bit(input logic [31:0] idx, input logic [31:0] n);
        return (idx > (n << 1)) ? 1'b1 : idx[0];
    endfunction

endpackage

// File: rtl/pattern_word_gen.sv
// pattern_word_gen: builds a word holding N overlapping 010 windows, streamed LSB first and presented in parallel
module pattern_word_gen
    import pattern_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] req_count,
    output logic             busy,
    output logic             dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic [WIDTH-1:0] word_out,
    output logic             word_valid
);

    localparam int IDX_W = $clog2(WIDTH);

    gen_state_t       state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] n_q, n_d;
    logic [WIDTH-1:0] word_q, word_d;
    logic             busy_q, busy_d;
    logic             wv_q, wv_d;
    logic             bit_w;

    assign bit_w      = pattern_bit(32'(idx_q), 32'(n_q));
    assign dout_valid = (state_q == SHIFT);
    assign dout       = dout_valid & bit_w;
    assign busy       = busy_q;
    assign word_out   = word_q;
    assign word_valid = wv_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            n_q     <= '0;
            word_q  <= '0;
            busy_q  <= 1'b0;
            wv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            n_q     <= n_d;
            word_q  <= word_d;
            busy_q  <= busy_d;
            wv_q    <= wv_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        n_d     = n_q;
        word_d  = word_q;
        busy_d  = busy_q;
        wv_d    = 1'b0;
        case (state_q)
            IDLE: begin
                // a start coinciding with word_valid is dropped so the finished word stays visible for a cycle
                if (start && !wv_q) begin
                    n_d     = req_count;
                    idx_d   = '0;
                    word_d  = '0;
                    busy_d  = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (dout_ready) begin
                    word_d[idx_q] = bit_w;
                    if (idx_q == IDX_W'(WIDTH - 1)) state_d = DONE;
                    else idx_d = idx_q + 1'b1;
                end
            end
            DONE: begin
                wv_d    = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule
